// File: rtl/uart_rx_pkg.sv
// Shared constants for the uart_rx_gen2 receiver: FSM state encoding,
// data-width limits and the prescale floor.
package uart_rx_pkg;

    // Legal range for the data-width parameter and the runtime DATA_LEN.
    localparam int DATA_W_MIN  = 5;
    localparam int DATA_W_MAX  = 9;

    // Smallest usable clk-per-bit count; smaller requests are raised to this.
    localparam int PRESC_FLOOR = 4;

    // Receiver FSM state encoding (plain constants for legacy compatibility).
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP1  = 3'd4;
    localparam state_t ST_STOP2  = 3'd5;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine for uart_rx_gen2: edge counter, bit counter and the
// line sampler. With UART_RX_MAJORITY_EN defined each bit is the majority
// of three samples centred on mid-bit; otherwise a single mid-bit sample.
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               start,     // IDLE exit: this cycle is edge 0
    input  logic               active,    // FSM is inside a frame
    input  logic [PRESC_W-1:0] presc,     // latched, clamped, even
    output logic               bit_end,   // current cycle is edge presc-1
    output logic               bit_val,   // bit decision, valid from decision edge to bit_end
    output logic [3:0]         bit_idx    // 0 = start bit, 1..N = data, then parity/stops
);

    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] edge_cnt_reg;
    logic [3:0]         bit_cnt_reg;
    logic               bit_hold_reg;

    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;
    logic [PRESC_W-1:0] dec_edge;
    logic               at_dec;
    logic               dec_now;

    assign half = presc >> 1;
    assign last = presc - P_ONE;

`ifdef UART_RX_MAJORITY_EN
    logic s_early_reg;
    logic s_mid_reg;

    // The third vote is the live line, so the decision lands on edge half+1.
    assign dec_edge = half + P_ONE;
    assign dec_now  = (s_early_reg & s_mid_reg) | (s_early_reg & rx) | (s_mid_reg & rx);

    // Capture the two early votes at edges half-1 and half.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_early_reg <= 1'b0;
            s_mid_reg   <= 1'b0;
        end else if (active) begin
            if (edge_cnt_reg == half - P_ONE) s_early_reg <= rx;
            if (edge_cnt_reg == half)         s_mid_reg   <= rx;
        end
    end
`else
    assign dec_edge = half;
    assign dec_now  = rx;
`endif

    assign at_dec  = active && (edge_cnt_reg == dec_edge);
    assign bit_end = active && (edge_cnt_reg == last);
    // At presc 4 with majority voting the decision edge equals bit_end, so
    // the live decision is forwarded rather than waiting for the hold register.
    assign bit_val = at_dec ? dec_now : bit_hold_reg;
    assign bit_idx = bit_cnt_reg;

    // Edge/bit counters and the held decision; start preloads edge 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            bit_hold_reg <= 1'b0;
        end else if (start) begin
            edge_cnt_reg <= P_ONE;
            bit_cnt_reg  <= '0;
        end else if (active) begin
            if (edge_cnt_reg == last) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + P_ONE;
            end
            if (at_dec) bit_hold_reg <= dec_now;
        end
    end

endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver with runtime frame format (5..DATA_W data bits, optional
// parity, one or two stop bits) and break detection. The frame format is
// latched when the start bit is first seen. Optional macro:
// UART_RX_MAJORITY_EN selects three-sample majority bit decisions.
module uart_rx_gen2
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [3:0]         DATA_LEN,
    input  logic               STOP2,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               brk_det
);

    localparam logic [PRESC_W-1:0] P_FLOOR = PRESC_W'(PRESC_FLOOR);
    localparam logic [3:0]         LEN_MIN = 4'(DATA_W_MIN);
    localparam logic [3:0]         LEN_MAX = 4'(DATA_W);

    state_t             state_reg, state_next;

    // Frame format captured at IDLE exit.
    logic [PRESC_W-1:0] presc_reg;
    logic               par_en_reg;
    logic               par_typ_reg;
    logic [3:0]         len_reg;
    logic               stop2_reg;

    // Per-frame accumulators.
    logic [DATA_W-1:0]  data_sh_reg;
    logic               par_acc_reg;
    logic               par_bad_reg;
    logic               stp_bad_reg;
    logic               all_zero_reg;

    // Registered outputs.
    logic [DATA_W-1:0]  p_data_reg;
    logic               valid_reg, par_err_reg, stp_err_reg, brk_reg;

    logic               start;
    logic               active;
    logic               bit_end;
    logic               bit_val;
    logic [3:0]         bit_idx;
    logic               frame_done;
    logic               brk_now;
    logic               stp_now;
    logic [PRESC_W-1:0] presc_clamped;
    logic [3:0]         len_clamped;
    logic [DATA_W-1:0]  cap_en;

    assign start  = (state_reg == ST_IDLE) && !RX_IN;
    assign active = (state_reg != ST_IDLE);

    // Raise tiny prescales to the floor and force an even count so mid-bit is exact.
    assign presc_clamped = (prescale < P_FLOOR) ? P_FLOOR : {prescale[PRESC_W-1:1], 1'b0};
    assign len_clamped   = (DATA_LEN < LEN_MIN) ? LEN_MIN :
                           (DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX_IN),
        .start   (start),
        .active  (active),
        .presc   (presc_reg),
        .bit_end (bit_end),
        .bit_val (bit_val),
        .bit_idx (bit_idx)
    );

    // Next-state logic; every transition happens on a bit boundary except IDLE exit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!RX_IN) state_next = ST_START;
            ST_START:  if (bit_end) state_next = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && (bit_idx == len_reg))
                           state_next = par_en_reg ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (bit_end) state_next = ST_STOP1;
            ST_STOP1:  if (bit_end) state_next = stop2_reg ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (bit_end) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign frame_done = bit_end &&
                        (((state_reg == ST_STOP1) && !stop2_reg) || (state_reg == ST_STOP2));
    // The final stop bit is folded in live since it never reaches the accumulators.
    assign brk_now    = all_zero_reg & ~bit_val;
    assign stp_now    = stp_bad_reg | ~bit_val;

    // One capture strobe per data bit position; bit_idx 1 is data bit 0 (LSB first).
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_cap
        assign cap_en[gi] = (state_reg == ST_DATA) && bit_end && (bit_idx == 4'(gi + 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Frame-format latch and per-frame accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            len_reg      <= '0;
            stop2_reg    <= 1'b0;
            data_sh_reg  <= '0;
            par_acc_reg  <= 1'b0;
            par_bad_reg  <= 1'b0;
            stp_bad_reg  <= 1'b0;
            all_zero_reg <= 1'b0;
        end else if (start) begin
            presc_reg    <= presc_clamped;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
            len_reg      <= len_clamped;
            stop2_reg    <= STOP2;
            data_sh_reg  <= '0;
            par_acc_reg  <= 1'b0;
            par_bad_reg  <= 1'b0;
            stp_bad_reg  <= 1'b0;
            all_zero_reg <= 1'b1;
        end else if (bit_end) begin
            all_zero_reg <= all_zero_reg & ~bit_val;
            data_sh_reg  <= (data_sh_reg & ~cap_en) | (cap_en & {DATA_W{bit_val}});
            case (state_reg)
                ST_DATA:   par_acc_reg <= par_acc_reg ^ bit_val;
                ST_PARITY: par_bad_reg <= ((par_acc_reg ^ bit_val) != par_typ_reg);
                ST_STOP1,
                ST_STOP2:  stp_bad_reg <= stp_bad_reg | ~bit_val;
                default:   ;
            endcase
        end
    end

    // Completion: publish data and exactly one prioritised status pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_data_reg  <= '0;
            valid_reg   <= 1'b0;
            par_err_reg <= 1'b0;
            stp_err_reg <= 1'b0;
            brk_reg     <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            par_err_reg <= 1'b0;
            stp_err_reg <= 1'b0;
            brk_reg     <= 1'b0;
            if (frame_done) begin
                p_data_reg <= data_sh_reg;
                if (brk_now)          brk_reg     <= 1'b1;
                else if (stp_now)     stp_err_reg <= 1'b1;
                else if (par_bad_reg) par_err_reg <= 1'b1;
                else                  valid_reg   <= 1'b1;
            end
        end
    end

    assign P_DATA     = p_data_reg;
    assign data_valid = valid_reg;
    assign par_err    = par_err_reg;
    assign stp_err    = stp_err_reg;
    assign brk_det    = brk_reg;

endmodule
